// File: rtl/unidade_controle_jogada.sv
// unidade_controle_jogada: Moore sequencer for one round of the sequence-memory game.
// Define UNIDADE_CONTROLE_JOGADA_TIMEOUT_EN to enable the per-play timeout and FIM_TIMEOUT.
module unidade_controle_jogada #(
   parameter int TIMEOUT_CICLOS = 3000,
   parameter int ESTADO_W       = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                jogada,
   input  logic                igual,
   input  logic                fimC,
   output logic                zeraC,
   output logic                contaC,
   output logic                zeraR,
   output logic                registraR,
   output logic                pronto,
   output logic                acertou,
   output logic                errou,
   output logic                timeout,
   output logic [ESTADO_W-1:0] db_estado
);
   typedef enum logic [3:0] {
      INICIAL     = 4'b0000,
      PREPARACAO  = 4'b0001,
      ESPERA      = 4'b0010,
      REGISTRA    = 4'b0100,
      COMPARACAO  = 4'b0101,
      PROXIMO     = 4'b0110,
      FIM_ACERTOU = 4'b1010,
`ifdef UNIDADE_CONTROLE_JOGADA_TIMEOUT_EN
      FIM_TIMEOUT = 4'b1101,
`endif
      FIM_ERROU   = 4'b1110
   } estado_t;
   estado_t estado, nxt;
   logic jogada_ant, press, expira, fim_to;
   assign press = jogada & ~jogada_ant;
   if (TIMEOUT_CICLOS < 2) begin : g_cfg
      $error("TIMEOUT_CICLOS must be at least 2");
   end
`ifdef UNIDADE_CONTROLE_JOGADA_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS);
   logic [TW-1:0] timer;
   // timer restarts on every visit to ESPERA so each play gets a full window
   always_ff @(posedge clock) begin
      if (reset || estado != ESPERA) timer <= '0;
      else if (timer != '1) timer <= timer + 1'b1;
   end
   assign expira = timer == TW'(TIMEOUT_CICLOS - 1);
   assign fim_to = nxt == FIM_TIMEOUT;
`else
   assign expira = 1'b0;
   assign fim_to = 1'b0;
`endif
   always_comb begin
      nxt = INICIAL;
      case (estado)
         INICIAL:     nxt = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO:  nxt = ESPERA;
`ifdef UNIDADE_CONTROLE_JOGADA_TIMEOUT_EN
         ESPERA:      nxt = press ? REGISTRA : expira ? FIM_TIMEOUT : ESPERA;
         FIM_TIMEOUT: nxt = iniciar ? PREPARACAO : FIM_TIMEOUT;
`else
         ESPERA:      nxt = press ? REGISTRA : ESPERA;
`endif
         REGISTRA:    nxt = COMPARACAO;
         COMPARACAO:  nxt = !igual ? FIM_ERROU : fimC ? FIM_ACERTOU : PROXIMO;
         PROXIMO:     nxt = ESPERA;
         FIM_ACERTOU: nxt = iniciar ? PREPARACAO : FIM_ACERTOU;
         FIM_ERROU:   nxt = iniciar ? PREPARACAO : FIM_ERROU;
         default:     nxt = INICIAL;
      endcase
   end
   // outputs are decoded from the next state so they change together with the state register
   always_ff @(posedge clock) begin
      if (reset) begin
         estado     <= INICIAL;
         jogada_ant <= 1'b0;
         zeraC      <= 1'b0;
         zeraR      <= 1'b0;
         registraR  <= 1'b0;
         contaC     <= 1'b0;
         pronto     <= 1'b0;
         acertou    <= 1'b0;
         errou      <= 1'b0;
         timeout    <= 1'b0;
         db_estado  <= '0;
      end else begin
         estado     <= nxt;
         jogada_ant <= jogada;
         zeraC      <= nxt == PREPARACAO;
         zeraR      <= nxt == PREPARACAO;
         registraR  <= nxt == REGISTRA;
         contaC     <= nxt == PROXIMO;
         pronto     <= nxt == FIM_ACERTOU || nxt == FIM_ERROU || fim_to;
         acertou    <= nxt == FIM_ACERTOU;
         errou      <= nxt == FIM_ERROU || fim_to;
         timeout    <= fim_to;
         db_estado  <= ESTADO_W'(nxt);
      end
   end
   logic unused;
   assign unused = expira;
endmodule

// File: tb/tb_unidade_controle_jogada.sv
// tb_unidade_controle_jogada: randomized rounds against a play-level model, verdicts checked through a scoreboard.
module tb_unidade_controle_jogada;
   localparam int T = 10;
`ifdef UNIDADE_CONTROLE_JOGADA_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fimC = 1'b0;
   logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;
   int cyc = 0, errors = 0, checks = 0;
   typedef struct {
      logic       a, e, t;
      logic [3:0] est;
      int         nreg, ncont, at;
   } exp_t;
   exp_t sb[$];
   int pd[6], ph[6];
   bit pig[6];
   logic jg[256], ig[256], fm[256], ini[256];

   unidade_controle_jogada #(.TIMEOUT_CICLOS(T), .ESTADO_W(4)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual), .fimC(fimC),
      .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
      .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // A round as seen by a player: each play waits pd cycles into ESPERA, holds the button ph cycles.
   task automatic run_round(input int n, input int gap);
      int c, e, k, early, p, v;
      exp_t x;
      c = cyc;
      e = c + 2;
      early = 0;
      v = -1;
      x = '{a: 0, e: 0, t: 0, est: 4'b0000, nreg: 0, ncont: 0, at: 0};
      for (int r = 0; r < 256; r++) begin
         jg[r] = 1'b0;
         ig[r] = 1'($urandom);
         fm[r] = 1'($urandom);
         ini[r] = $urandom_range(0, 3) == 0;
      end
      for (int i = 0; i < n && v < 0; i++) begin
         k = pd[i] > early ? pd[i] : early;
         if (TO_EN && k >= T) begin
            v = e + T;
            x = '{a: 0, e: 1, t: 1, est: 4'b1101, nreg: i, ncont: i, at: v};
         end else begin
            p = e + k;
            for (int j = p; j < p + ph[i]; j++) jg[j - c] = 1'b1;
            ig[p + 2 - c] = pig[i];
            fm[p + 2 - c] = i == n - 1;
            if (!pig[i]) begin
               v = p + 3;
               x = '{a: 0, e: 1, t: 0, est: 4'b1110, nreg: i + 1, ncont: i, at: v};
            end else if (i == n - 1) begin
               v = p + 3;
               x = '{a: 1, e: 0, t: 0, est: 4'b1010, nreg: n, ncont: n - 1, at: v};
            end else begin
               e = p + 4;
               early = ph[i] >= 4 ? ph[i] - 3 : 0;
            end
         end
      end
      sb.push_back(x);
      for (int r = 0; r < v - c; r++) begin
         iniciar = r == 0 ? 1'b1 : ini[r];
         jogada = jg[r];
         igual = ig[r];
         fimC = fm[r];
         step();
      end
      iniciar = 1'b0;
      jogada = 1'b0;
      repeat (gap) step();
   endtask

   task automatic set_plays(input int n, input int d, input int h);
      for (int i = 0; i < 6; i++) begin
         pd[i] = d;
         ph[i] = h;
         pig[i] = 1'b1;
      end
   endtask

   initial begin : monitor
      int nreg, ncont;
      logic pr_d;
      exp_t x;
      nreg = 0;
      ncont = 0;
      pr_d = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (zeraC) begin
            nreg = 0;
            ncont = 0;
         end
         nreg += int'(registraR);
         ncont += int'(contaC);
         if (pronto && !pr_d) begin
            if (sb.size() == 0) chk("unexpected_verdict", 1, 0);
            else begin
               x = sb.pop_front();
               chk("acertou", acertou, x.a);
               chk("errou", errou, x.e);
               chk("timeout", timeout, x.t);
               chk("verdict_state", db_estado, x.est);
               chk("registraR_pulses", nreg, x.nreg);
               chk("contaC_pulses", ncont, x.ncont);
               chk("verdict_cycle", cyc, x.at);
            end
         end
         pr_d = pronto;
         chk("single_ctrl", int'(zeraC) + int'(registraR) + int'(contaC) <= 1, 1);
         chk("zeraR_with_zeraC", zeraR, zeraC);
         chk("pronto_decode", pronto, acertou | errou);
         if (zeraC) chk("prep_state", db_estado, 4'b0001);
         if (registraR) chk("registra_state", db_estado, 4'b0100);
         if (contaC) chk("proximo_state", db_estado, 4'b0110);
      end
   end

   initial begin : stimulus
      int c;
      repeat (2) step();
      chk("reset_state", db_estado, 0);
      chk("reset_outputs", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}, 0);
      reset = 1'b0;
      chk("idle_state", db_estado, 0);
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      chk("start_prep", db_estado, 1);
      chk("start_zeraC", zeraC, 1);
      step();
      chk("start_espera", db_estado, 2);
      chk("zeraC_one_cycle", zeraC, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_from_espera", db_estado, 0);
      set_plays(4, 1, 1);
      run_round(4, 2);
      set_plays(4, 0, 2);
      pig[1] = 1'b0;
      run_round(4, 1);
      set_plays(3, 0, 7);
      run_round(3, 0);
      set_plays(2, 2, 5);
      pd[1] = 0;
      run_round(2, 1);
`ifdef UNIDADE_CONTROLE_JOGADA_TIMEOUT_EN
      set_plays(2, T - 1, 1);
      run_round(2, 1);
      set_plays(1, 50, 1);
      run_round(1, 2);
      set_plays(3, 0, 1);
      pd[2] = T;
      run_round(3, 0);
`endif
      for (int rr = 0; rr < 40; rr++) begin
         for (int i = 0; i < 6; i++) begin
            pd[i] = $urandom_range(0, 3) == 0 ? $urandom_range(0, 14) : $urandom_range(0, 4);
            ph[i] = $urandom_range(1, 7);
            pig[i] = $urandom_range(0, 5) != 0;
         end
         run_round($urandom_range(1, 5), $urandom_range(0, 3));
      end
      c = cyc;
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      step();
      jogada = 1'b1;
      step();
      jogada = 1'b0;
      step();
      chk("comparacao_state", db_estado, 4'b0101);
      chk("comparacao_cycle", cyc - c, 4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midround_reset_state", db_estado, 0);
      chk("midround_reset_outputs", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}, 0);
`ifndef UNIDADE_CONTROLE_JOGADA_TIMEOUT_EN
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      repeat (5001) step();
      chk("no_timeout_state", db_estado, 2);
      chk("no_timeout_flag", timeout, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
`endif
      repeat (4) step();
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
